// File: rtl/aes_stream_ctrl.sv
// AES stream controller: accepts one block request at a time, runs key expansion (cached)
// and the selected cipher core, and queues results in a small in-order FIFO.

package aes_stream_pkg;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // b^254 == multiplicative inverse in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] b);
    logic [7:0] p, r;
    p = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int k = 0; k < 16; k++)
      o[8*k +: 8] = inv ? inv_sbox(s[8*k +: 8]) : sbox(s[8*k +: 8]);
    return o;
  endfunction

  // byte r+4c sits at bits 127-8*(r+4c); row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!inv) o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        else      o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [3:0][7:0] k;
    logic [31:0] o;
    logic [7:0] b;
    k = inv ? {8'h0e, 8'h0b, 8'h0d, 8'h09} : {8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++)
        b = b ^ gmul(k[3-((j-i+4)%4)], c[31-8*j -: 8]);
      o[31-8*i -: 8] = b;
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    return o;
  endfunction
endpackage

// Iterative key schedule, one word per cycle. reset loads key/Nk; schedule holds once done.
module KeyExpansion (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        nk,
  input  logic [255:0]      key,
  output logic [59:0][31:0] w,
  output logic              keyExpansionDone
);
  import aes_stream_pkg::*;

  logic [255:0] kal;
  logic [5:0]   i;
  logic [2:0]   mcnt;
  logic [7:0]   rcon;
  logic [3:0]   nk_r;
  logic [31:0]  prev, temp;

  // left-align the key so word j is always at a fixed position
  assign kal = key << {4'd8 - nk, 5'd0};

  always_comb begin
    prev = w[i - 6'd1];
    if (mcnt == 3'd0)                       temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    else if (nk_r == 4'd8 && mcnt == 3'd4)  temp = sub_word(prev);
    else                                    temp = prev;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 8; j++)  w[j] <= kal[255-32*j -: 32];
      for (int j = 8; j < 60; j++) w[j] <= 32'h0;
      i                <= {2'b00, nk};
      mcnt             <= 3'd0;
      rcon             <= 8'h01;
      nk_r             <= nk;
      keyExpansionDone <= 1'b0;
    end else if (!keyExpansionDone) begin
      w[i] <= w[i - {2'b00, nk_r}] ^ temp;
      i    <= i + 6'd1;
      mcnt <= ({1'b0, mcnt} == nk_r - 4'd1) ? 3'd0 : mcnt + 3'd1;
      if (mcnt == 3'd0) rcon <= xt(rcon);
      if (i == {nk_r, 2'b00} + 6'd27) keyExpansionDone <= 1'b1;
    end
  end
endmodule

// One round per cycle; reset loads the block and applies round key 0.
module Cipher (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        nr,
  input  logic [59:0][31:0] w,
  input  logic [127:0]      din,
  output logic [127:0]      dout,
  output logic              done
);
  import aes_stream_pkg::*;

  logic [3:0]   rnd, ki;
  logic [127:0] rk, t;

  assign ki = reset ? 4'd0 : rnd;
  assign rk = {w[{ki, 2'b00}], w[{ki, 2'b01}], w[{ki, 2'b10}], w[{ki, 2'b11}]};
  assign t  = shift_rows(sub_bytes(dout, 1'b0), 1'b0);

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= din ^ rk;
      rnd  <= 4'd1;
      done <= 1'b0;
    end else if (!done) begin
      dout <= ((rnd == nr) ? t : mix_columns(t, 1'b0)) ^ rk;
      if (rnd == nr) done <= 1'b1;
      else           rnd  <= rnd + 4'd1;
    end
  end
endmodule

// Straight inverse cipher on the forward schedule, rounds Nr down to 0.
module Decipher (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        nr,
  input  logic [59:0][31:0] w,
  input  logic [127:0]      din,
  output logic [127:0]      dout,
  output logic              done
);
  import aes_stream_pkg::*;

  logic [3:0]   rnd, ki;
  logic [127:0] rk, t;

  assign ki = reset ? nr : rnd;
  assign rk = {w[{ki, 2'b00}], w[{ki, 2'b01}], w[{ki, 2'b10}], w[{ki, 2'b11}]};
  assign t  = sub_bytes(shift_rows(dout, 1'b1), 1'b1) ^ rk;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= din ^ rk;
      rnd  <= nr - 4'd1;
      done <= 1'b0;
    end else if (!done) begin
      if (rnd == 4'd0) begin
        dout <= t;
        done <= 1'b1;
      end else begin
        dout <= mix_columns(t, 1'b1);
        rnd  <= rnd - 4'd1;
      end
    end
  end
endmodule

module aes_stream_ctrl #(
  parameter int OUT_DEPTH = 2,
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         inValid,
  output logic         inReady,
  input  logic         inMode,
  input  logic [7:0]   inNk,
  input  logic [255:0] inKey,
  input  logic [127:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outData,
  output logic         outMode,
  output logic         outErr,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, KEY_EXP, RUN, PUSH} state_t;
  typedef struct packed {
    logic         err;
    logic         mode;
    logic [127:0] data;
  } entry_t;

  state_t state, state_nxt;

  logic         mode_q, err_q;
  logic [3:0]   nk_q, cache_nk, nr;
  logic [255:0] key_q, cache_key;
  logic [127:0] data_q, res_q;
  logic         cache_valid, kx_run, run_go;
  logic         accept, nk_ok, hit, core_done;
  logic         kx_rst, enc_rst, dec_rst;
  logic         kx_done, enc_done, dec_done;
  logic [59:0][31:0] kx_w;
  logic [127:0] enc_out, dec_out;

  entry_t       mem [4];
  entry_t       head;
  logic [1:0]   rd_ptr, wr_ptr;
  logic [2:0]   count;
  logic         push, pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(OUT_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign inReady   = resetN && (state == IDLE) && (count < 3'(OUT_DEPTH));
  assign accept    = inValid && inReady;
  assign nk_ok     = (inNk == 8'd4) || (inNk == 8'd6) || (inNk == 8'd8);
  assign hit       = (KEY_CACHE != 0) && cache_valid && (inNk[3:0] == cache_nk) && (inKey == cache_key);
  assign core_done = mode_q ? dec_done : enc_done;
  assign busy      = (state != IDLE);
  assign nr        = nk_q + 4'd6;

  // Each core loads while in reset, so a one-cycle reset precedes every release.
  assign kx_rst  = !(cache_valid || (state == KEY_EXP && kx_run));
  assign enc_rst = !(state == RUN && run_go && !mode_q);
  assign dec_rst = !(state == RUN && run_go && mode_q);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = !nk_ok ? PUSH : (hit ? RUN : KEY_EXP);
      KEY_EXP: if (kx_run && kx_done) state_nxt = RUN;
      RUN:     if (run_go && core_done) state_nxt = PUSH;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      nk_q        <= 4'd0;
      key_q       <= '0;
      data_q      <= '0;
      res_q       <= '0;
      cache_valid <= 1'b0;
      cache_nk    <= 4'd0;
      cache_key   <= '0;
      kx_run      <= 1'b0;
      run_go      <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (accept) begin
          mode_q <= inMode;
          nk_q   <= inNk[3:0];
          key_q  <= inKey;
          data_q <= inData;
          err_q  <= !nk_ok;
          res_q  <= '0;
          run_go <= 1'b0;
          kx_run <= 1'b0;
          if (nk_ok && !hit) cache_valid <= 1'b0;
        end
        KEY_EXP: begin
          if (kx_run && kx_done) begin
            cache_valid <= 1'b1;
            cache_key   <= key_q;
            cache_nk    <= nk_q;
            kx_run      <= 1'b0;
          end else begin
            kx_run <= 1'b1;
          end
        end
        RUN: begin
          if (run_go && core_done) begin
            res_q  <= mode_q ? dec_out : enc_out;
            run_go <= 1'b0;
          end else begin
            run_go <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  KeyExpansion u_kx (
    .clk(clk), .reset(kx_rst), .nk(nk_q), .key(key_q), .w(kx_w), .keyExpansionDone(kx_done)
  );
  Cipher u_enc (
    .clk(clk), .reset(enc_rst), .nr(nr), .w(kx_w), .din(data_q), .dout(enc_out), .done(enc_done)
  );
  Decipher u_dec (
    .clk(clk), .reset(dec_rst), .nr(nr), .w(kx_w), .din(data_q), .dout(dec_out), .done(dec_done)
  );

  // Result FIFO; a slot was reserved at accept, so push never meets a full queue.
  assign push     = (state == PUSH);
  assign pop      = outValid && outReady;
  assign outValid = (count != 3'd0);
  assign head     = mem[rd_ptr];
  assign outData  = head.data;
  assign outMode  = head.mode;
  assign outErr   = head.err;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int j = 0; j < 4; j++) mem[j] <= '0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {err_q, mode_q, err_q ? 128'h0 : res_q};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl using FIPS-197 example vectors.
module tb_aes_stream_ctrl;
  logic         clk = 1'b0;
  logic         resetN, inValid, inMode, outReady;
  logic [7:0]   inNk;
  logic [255:0] inKey;
  logic [127:0] inData;
  logic         inReady, outValid, outMode, outErr, busy;
  logic [127:0] outData;

  int tests = 0;
  int fails = 0;

  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_stream_ctrl #(.OUT_DEPTH(2), .KEY_CACHE(1)) dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady), .inMode(inMode),
    .inNk(inNk), .inKey(inKey), .inData(inData), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outMode(outMode), .outErr(outErr), .busy(busy)
  );

  always #5 clk = ~clk;

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic m, input logic [7:0] nk, input logic [255:0] k, input logic [127:0] d);
    int n = 0;
    inMode = m; inNk = nk; inKey = k; inData = d; inValid = 1'b1;
    while (!inReady && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (!inReady) begin fails++; $display("FAIL accept_timeout: inReady=%b after %0d cycles", inReady, n); end
    @(posedge clk); #1 inValid = 1'b0;
    @(negedge clk);
  endtask

  // lat = rising edges from the accepting edge until outValid is seen
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!outValid && lat < 400) begin @(negedge clk); lat++; end
    tests++;
    if (!outValid) begin fails++; $display("FAIL out_timeout: outValid=%b after %0d cycles", outValid, lat); end
  endtask

  task automatic pop();
    outReady = 1'b1; @(posedge clk); #1 outReady = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetN = 1'b0; inValid = 1'b0; inMode = 1'b0; inNk = 8'd0; inKey = '0; inData = '0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (outValid !== 1'b0) begin fails++; $display("FAIL rst_outValid: got %b want 0", outValid); end
    tests++; if (outData !== 128'h0) begin fails++; $display("FAIL rst_outData: got %h want 0", outData); end
    tests++; if ({outMode, outErr} !== 2'b00) begin fails++; $display("FAIL rst_mode_err: got %b want 00", {outMode, outErr}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (inReady !== 1'b0) begin fails++; $display("FAIL rst_inReady: got %b want 0", inReady); end
    resetN = 1'b1;
    @(negedge clk);
    tests++; if (inReady !== 1'b1) begin fails++; $display("FAIL post_rst_inReady: got %b want 1", inReady); end
  endtask

  task automatic test_enc128();
    int lat;
    send(1'b0, 8'd4, K128, PT);
    wait_valid(lat);
    tests++; if (outData !== C128) begin fails++; $display("FAIL enc128_data: got %h want %h", outData, C128); end
    tests++; if ({outMode, outErr} !== 2'b00) begin fails++; $display("FAIL enc128_mode_err: got %b want 00", {outMode, outErr}); end
    tests++; if (lat <= 40) begin fails++; $display("FAIL enc128_keyexp_latency: got %0d want >40", lat); end
    pop();
    tests++; if (outValid !== 1'b0) begin fails++; $display("FAIL enc128_popped: outValid got %b want 0", outValid); end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    send(1'b0, 8'd4, K128, PT);
    wait_valid(lat);
    tests++; if (lat >= 30) begin fails++; $display("FAIL hit1_latency: got %0d want <30", lat); end
    send(1'b1, 8'd4, K128, C128);
    n = 1;
    while (busy && n < 400) begin @(negedge clk); n++; end
    tests++; if (n >= 30) begin fails++; $display("FAIL hit2_latency: got %0d want <30", n); end
    tests++; if (inReady !== 1'b0) begin fails++; $display("FAIL full_inReady: got %b want 0", inReady); end
    tests++; if (outData !== C128 || outMode !== 1'b0) begin fails++; $display("FAIL head1: got %h/%b want %h/0", outData, outMode, C128); end
    pop();
    tests++; if (inReady !== 1'b1) begin fails++; $display("FAIL pop_full_inReady: got %b want 1", inReady); end
    tests++; if (outValid !== 1'b1 || outData !== PT || outMode !== 1'b1) begin
      fails++; $display("FAIL head2: got v=%b %h/%b want v=1 %h/1", outValid, outData, outMode, PT);
    end
    pop();
    tests++; if (outValid !== 1'b0) begin fails++; $display("FAIL b2b_drained: outValid got %b want 0", outValid); end
  endtask

  task automatic test_error();
    int lat;
    send(1'b1, 8'd5, K128, PT);
    tests++; if (outValid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL err_cycle1: got v=%b busy=%b want v=0 busy=1", outValid, busy); end
    @(negedge clk);
    tests++; if (outValid !== 1'b1 || outErr !== 1'b1) begin fails++; $display("FAIL err_entry: got v=%b err=%b want 1/1", outValid, outErr); end
    tests++; if (outData !== 128'h0 || outMode !== 1'b1) begin fails++; $display("FAIL err_payload: got %h/%b want 0/1", outData, outMode); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL err_idle: busy got %b want 0", busy); end
    pop();
    send(1'b0, 8'd4, K128, PT);
    wait_valid(lat);
    tests++; if (lat >= 30) begin fails++; $display("FAIL err_cache_kept_latency: got %0d want <30", lat); end
    tests++; if (outData !== C128 || outErr !== 1'b0) begin fails++; $display("FAIL err_next_data: got %h/%b want %h/0", outData, outErr, C128); end
    pop();
  endtask

  task automatic test_dec_long_keys();
    int lat;
    send(1'b1, 8'd6, K192, C192);
    wait_valid(lat);
    tests++; if (outData !== PT || outMode !== 1'b1 || outErr !== 1'b0) begin
      fails++; $display("FAIL dec192: got %h/%b/%b want %h/1/0", outData, outMode, outErr, PT);
    end
    tests++; if (lat <= 40) begin fails++; $display("FAIL dec192_latency: got %0d want >40", lat); end
    pop();
    send(1'b1, 8'd8, K256, C256);
    wait_valid(lat);
    tests++; if (outData !== PT || outMode !== 1'b1) begin fails++; $display("FAIL dec256: got %h/%b want %h/1", outData, outMode, PT); end
    tests++; if (lat <= 40) begin fails++; $display("FAIL dec256_latency: got %0d want >40", lat); end
    pop();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    send(1'b0, 8'd4, K128, PT);
    repeat (46) @(negedge clk);
    tests++; if (busy !== 1'b1 || outValid !== 1'b0) begin fails++; $display("FAIL midrun_busy: got busy=%b v=%b want 1/0", busy, outValid); end
    resetN = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || outValid !== 1'b0 || inReady !== 1'b0) begin
      fails++; $display("FAIL midrun_reset: got busy=%b v=%b rdy=%b want 0/0/0", busy, outValid, inReady);
    end
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (outValid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrun_no_partial: got v=%b busy=%b want 0/0", outValid, busy); end
    send(1'b0, 8'd4, K128, PT);
    wait_valid(lat);
    tests++; if (lat <= 40) begin fails++; $display("FAIL midrun_reexpand_latency: got %0d want >40", lat); end
    tests++; if (outData !== C128 || outErr !== 1'b0) begin fails++; $display("FAIL midrun_rerun_data: got %h want %h", outData, C128); end
    pop();
  endtask

  initial begin
    test_reset();
    test_enc128();
    test_back_to_back();
    test_error();
    test_dec_long_keys();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/aes_stream_ctrl.md
AES_STREAM_CTRL -- requirements
Module: aes_stream_ctrl

Interface
REQ-001 SHALL provide parameter OUT_DEPTH, default 2, meaning number of result FIFO entries (legal 1..4).
REQ-002 SHALL provide parameter KEY_CACHE, default 1, meaning 1 = reuse the expanded key schedule when key and Nk are unchanged, 0 = always re-expand.
REQ-003 SHALL provide port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL provide port resetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port inValid  input  1  request present.
REQ-006 SHALL provide port inReady  output  1  controller can accept a request.
REQ-007 SHALL provide port inMode  input  1  0 = encrypt (Cipher), 1 = decrypt (Decipher).
REQ-008 SHALL provide port inNk  input  8  key length in words (4/6/8).
REQ-009 SHALL provide port inKey  input  256  cipher key, right-aligned (AES-128 in bits 127:0).
REQ-010 SHALL provide port inData  input  128  plaintext or ciphertext block.
REQ-011 SHALL provide port outValid  output  1  FIFO head valid.
REQ-012 SHALL provide port outReady  input  1  consumer takes head.
REQ-013 SHALL provide port outData  output  128  result block at FIFO head.
REQ-014 SHALL provide port outMode  output  1  mode of head entry.
REQ-015 SHALL provide port outErr  output  1  head entry rejected (illegal Nk).
REQ-016 SHALL provide port busy  output  1  high when state is not IDLE.
REQ-017 SHALL instantiate existing KeyExpansion, Cipher and Decipher cores, each driven by its own active-high reset from this block.

Function
REQ-018 SHALL implement states IDLE, KEY_EXP, RUN, PUSH.
REQ-019 SHALL drive inReady = (state == IDLE) && (FIFO count < OUT_DEPTH); accept on inValid && inReady, latching mode, Nk, key, data.
REQ-020 SHALL, on accept with Nk not in {4,6,8}, skip all cores, go to PUSH and write entry {outErr=1, outData=0, outMode=latched mode}; cache state unchanged.
REQ-021 SHALL, on legal accept with KEY_CACHE=1, cache valid, and Nk and key equal to the cached ones, go directly to RUN; otherwise go to KEY_EXP.
REQ-022 SHALL, in KEY_EXP, release the KeyExpansion reset, hold it released until keyExpansionDone, then record key/Nk as cached, set cache valid, and go to RUN.
REQ-023 SHALL, in RUN, release only the core selected by mode (other held in reset) and wait for its done, then capture its 128-bit result and go to PUSH.
REQ-024 SHALL, in PUSH, write {result, mode, err=0} to FIFO tail, reassert the active core's reset, and return to IDLE the next cycle (one request in flight at a time).
REQ-025 SHALL keep the KeyExpansion schedule output stable (core not reset) while cache is valid; a cache miss resets it for 1 cycle before release.
REQ-026 SHALL treat a mode change with identical key/Nk as a cache hit.
REQ-027 SHALL present FIFO head combinationally on outData/outMode/outErr; pop on outValid && outReady; order strictly FIFO.
REQ-028 SHALL, on simultaneous push and pop, keep count unchanged and preserve order; pop from full makes inReady high the next cycle.
REQ-029 SHALL never overflow: slot is reserved at accept by the count check in REQ-019.
REQ-030 SHALL add exactly 1 cycle (PUSH) after core done before outValid can rise, and reach IDLE 1 cycle after PUSH.

Reset
REQ-031 SHALL, on resetN low, immediately force state IDLE, FIFO empty, outValid=0, outData=0, outMode=0, outErr=0, busy=0, inReady=0 while reset is held, cache invalid, all core resets asserted.
REQ-032 SHALL abandon any in-flight request on reset mid-operation; no partial result is ever pushed.

Verification
REQ-033 SHALL cover: enc, Nk=4, key 000102..0f, data 00112233445566778899aabbccddeeff -> outData 69c4e0d86a7b0430d8cdb78070b4c55a, outErr=0.
REQ-034 SHALL cover: dec, Nk=6, key 000102..17, data dda97ca4864cdfe06eaf70a0ec0d7191 -> outData 00112233445566778899aabbccddeeff; then dec, Nk=8, key 000102..1f, data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext.
REQ-035 SHALL cover: enc then dec with same Nk=4 key -> second request never enters KEY_EXP (cache hit), results correct and in order.
REQ-036 SHALL cover: inNk=5 -> entry with outErr=1, outData=0 after 2 cycles, no core reset released.
REQ-037 SHALL cover: outReady=0 with OUT_DEPTH=2 -> two results queue, inReady=0; single pop -> inReady=1 next cycle, order preserved.
REQ-038 SHALL cover: resetN pulsed low during RUN -> FIFO empty, busy=0, next identical request re-runs KEY_EXP and returns correct result.
